// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the serial instruction-memory boot loader.
package instr_loader_pkg;

  localparam int HDR_W            = 16;  // big-endian word count field
  localparam int CSUM_W           = 8;   // XOR checksum byte
  localparam int DEF_CLKS_PER_BIT = 434; // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/instr_loader_uart_rx.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid/error pulses.
module uart_rx_byte
  import instr_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t      rs, rs_n;
  logic           sync1, rx_s, rx_prev;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shreg, sh_n;

  // Line idles high, so the synchronizer resets high to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rs      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      rs      <= rs_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    rs_n       = rs;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    sh_n       = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rs)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rs_n  = RX_START;
          cnt_n = '0;
        end
      end
      RX_START: begin
        // Re-check mid start bit; a high level here was only a glitch.
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          bit_n = '0;
          rs_n  = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, shreg[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rs_n = RX_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_n      = '0;
          rs_n       = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: rs_n = RX_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a framed UART image and writes it word by word into instruction memory.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              Sys_Clock,
  input  logic              Reset,
  input  logic              Rx_Serial,
  input  logic              Load_Enable,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Cpu_Hold,
  output logic              Load_Done,
  output logic              Load_Err,
  output logic [ADDR_W:0]   Word_Count
);

  localparam int MAX_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] WC_ONE = 1;

  state_t              state, state_n;
  logic [7:0]          byte_data;
  logic                byte_valid, frame_err;
  logic [HDR_W-1:0]    n_words, hdr_n;
  logic [CSUM_W-1:0]   csum;
  logic [1:0]          byte_cnt;
  logic [DATA_W-9:0]   word_sh;
  logic [ADDR_W:0]     wc_inc;
  logic                word_done;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (Sys_Clock),
    .rst        (Reset),
    .rx         (Rx_Serial),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign hdr_n     = {n_words[HDR_W-1:8], byte_data};
  assign wc_inc    = Word_Count + WC_ONE;
  assign word_done = (state == S_DATA) && byte_valid && (byte_cnt == 2'd3);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (Load_Enable) state_n = S_HDR_HI;
      S_HDR_HI: begin
        if (frame_err)       state_n = S_ERROR;
        else if (byte_valid) state_n = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (frame_err) state_n = S_ERROR;
        else if (byte_valid)
          state_n = (hdr_n == '0 || int'(hdr_n) > MAX_WORDS) ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (frame_err) state_n = S_ERROR;
        else if (word_done && HDR_W'(wc_inc) == n_words) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (frame_err) state_n = S_ERROR;
        else if (byte_valid) state_n = (byte_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (!Load_Enable) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      Mem_Write  <= 1'b0;
      Mem_Addr   <= '0;
      Mem_Data   <= '0;
      Cpu_Hold   <= 1'b0;
      Load_Done  <= 1'b0;
      Load_Err   <= 1'b0;
      Word_Count <= '0;
      n_words    <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      word_sh    <= '0;
    end else begin
      state     <= state_n;
      Mem_Write <= 1'b0;
      if (state == S_IDLE && state_n == S_HDR_HI) begin
        Cpu_Hold   <= 1'b1;
        Word_Count <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
        Load_Done  <= 1'b0;
        Load_Err   <= 1'b0;
      end
      if (state == S_HDR_HI && byte_valid) n_words[HDR_W-1:8] <= byte_data;
      if (state == S_HDR_LO && byte_valid) n_words <= hdr_n;
      // Assemble in a side register so Mem_Data only changes when a word completes.
      if (state == S_DATA && byte_valid) begin
        csum     <= csum ^ byte_data;
        byte_cnt <= byte_cnt + 2'd1;
        word_sh  <= {word_sh[DATA_W-17:0], byte_data};
        if (word_done) begin
          Mem_Write  <= 1'b1;
          Mem_Addr   <= Word_Count[ADDR_W-1:0];
          Mem_Data   <= {word_sh, byte_data};
          Word_Count <= wc_inc;
        end
      end
      if (state_n == S_DONE && state != S_DONE) begin
        Load_Done <= 1'b1;
        Cpu_Hold  <= 1'b0;
      end
      // Cpu_Hold is left set so a corrupt image never runs.
      if (state_n == S_ERROR && state != S_ERROR) Load_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader with a 4-clock bit period.
module tb_instr_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 0;
  logic              rst = 1;
  logic              rx = 1;
  logic              load_en = 0;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              cpu_hold, load_done, load_err;
  logic [ADDR_W:0]   word_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .Sys_Clock   (clk),
    .Reset       (rst),
    .Rx_Serial   (rx),
    .Load_Enable (load_en),
    .Mem_Write   (mem_write),
    .Mem_Addr    (mem_addr),
    .Mem_Data    (mem_data),
    .Cpu_Hold    (cpu_hold),
    .Load_Done   (load_done),
    .Load_Err    (load_err),
    .Word_Count  (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && mem_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_data, e.data);
        chk("wr_count", word_count, e.addr + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  // Reference: decide the outcome of an image purely from the framing rules.
  task automatic run_load(input bq_t img, input int bad_idx, input bit glitch);
    int   n, nwr, last;
    bit   len_ok, done;
    logic [7:0] x;
    n      = (img.size() >= 2) ? {img[0], img[1]} : 0;
    len_ok = (n != 0) && (n <= (1 << ADDR_W));
    nwr    = 0;
    x      = 8'h00;
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        last = 2 + 4 * i + 3;
        if (last < img.size() && (bad_idx < 0 || bad_idx > last)) begin
          wr_t w;
          w.addr = ADDR_W'(i);
          w.data = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
          exp_q.push_back(w);
          nwr++;
        end
      end
      for (int i = 2; i < 2 + 4 * n && i < img.size(); i++) x ^= img[i];
    end
    done = len_ok && bad_idx < 0 && img.size() == 2 + 4 * n + 1 && img[img.size()-1] == x;

    load_en = 1'b1;
    tick(2);
    chk("hold_on_start", cpu_hold, 1);
    if (glitch) begin
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(12);
      chk("glitch_no_change", {cpu_hold, load_err, load_done}, 3'b100);
    end
    foreach (img[i]) send_byte(img[i], i != bad_idx);
    tick(10);
    chk("writes_drained", exp_q.size(), 0);
    chk("load_done", load_done, done);
    chk("load_err", load_err, !done);
    chk("cpu_hold", cpu_hold, !done);
    chk("word_count", word_count, nwr);
    load_en = 1'b0;
    tick(3);
    chk("flags_held", {load_done, load_err}, {done, !done});
    exp_q.delete();
  endtask

  function automatic logic [7:0] xor_data(input bq_t img);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    return x;
  endfunction

  initial begin
    bq_t img;
    tick(3);
    chk("reset_outputs",
        {mem_write, mem_addr, mem_data, cpu_hold, load_done, load_err, word_count}, 0);
    rst = 1'b0;
    tick(3);

    // Nominal: checksum 0x2A is the XOR of the eight data bytes.
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
    run_load(img, -1, 0);

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h05};
    run_load(img, -1, 0);

    // Stop bit low on the third data byte, remaining bytes still sent.
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
    run_load(img, 4, 0);

    img = '{8'h00, 8'h00};
    run_load(img, -1, 0);
    img = '{8'h20, 8'h01};
    run_load(img, -1, 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 3);
      img = '{8'h00, 8'(n)};
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      img.push_back(xor_data(img) ^ 8'($urandom_range(0, 1)));
      run_load(img, -1, 0);
    end

    // Reset after the first of two words has been written.
    exp_q.push_back('{addr: '0, data: 32'hCAFE_F00D});
    load_en = 1'b1;
    tick(2);
    img = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    foreach (img[i]) send_byte(img[i], 1'b1);
    tick(4);
    chk("mid_first_write", exp_q.size(), 0);
    chk("mid_hold", cpu_hold, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {mem_write, mem_addr, mem_data, cpu_hold, load_done, load_err, word_count}, 0);
    load_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    img = '{8'h00, 8'h01, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00};
    img[6] = xor_data(img);
    run_load(img, -1, 0);

    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(img, -1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
